// File: rtl/nav_motor_controller.sv
// nav_motor_controller
//   Obstacle-avoidance motor controller for the RC platform. Front/left/right
//   range samples feed a hysteretic front-obstacle flag; an FSM runs a
//   forward / back-up / turn-toward-open-side sequence with programmable
//   durations and latches a fault once the retry budget is spent. The motor
//   enable is a PWM whose duty only changes at period boundaries.
//
//   Ports:
//     clk            in   system clock (125 MHz)
//     reset          in   synchronous, active-high
//     enable         in   run request; low forces STOP and clears a fault
//     dist_valid     in   one-cycle strobe, all three distances valid
//     distance_front in   DIST_W front range sample
//     distance_left  in   DIST_W left range sample
//     distance_right in   DIST_W right range sample
//     speed          in   PWM_W forward duty
//     direction      out  one-hot: FWD 00001, BACK 00010, LEFT 00100,
//                         RIGHT 01000, STOP 10000
//     pwm_signal     out  motor enable PWM
//     fault          out  boxed-in fault latched
//
//   Build option: define MOTOR_SOFTSTART_EN to ramp the PWM duty by one step
//   per PWM period toward its target instead of jumping to it.
module nav_motor_controller #(
    parameter int DIST_W           = 16,
    parameter int OBST_TH          = 13,
    parameter int HYST             = 4,
    parameter int BACKUP_CYCLES    = 6250000,
    parameter int TURN_CYCLES      = 16777215,
    parameter int FWD_CLEAR_CYCLES = 12500000,
    parameter int MAX_RETRY        = 3,
    parameter int PWM_W            = 8,
    parameter logic [PWM_W-1:0] TURN_DUTY = 8'd160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] distance_front,
    input  logic [DIST_W-1:0] distance_left,
    input  logic [DIST_W-1:0] distance_right,
    input  logic [PWM_W-1:0]  speed,
    output logic [4:0]        direction,
    output logic              pwm_signal,
    output logic              fault
);

    localparam int TMR_MAX = (BACKUP_CYCLES > TURN_CYCLES) ? BACKUP_CYCLES : TURN_CYCLES;
    localparam int TMR_W   = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
    localparam int CLR_W   = ($clog2(FWD_CLEAR_CYCLES) < 1) ? 1 : $clog2(FWD_CLEAR_CYCLES);

    localparam logic [TMR_W-1:0]  BACK_LOAD = TMR_W'(BACKUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TURN_LOAD = TMR_W'(TURN_CYCLES - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(FWD_CLEAR_CYCLES - 1);
    localparam logic [3:0]        MAX_R     = 4'(MAX_RETRY);

    // Thresholds are one bit wider than the samples so OBST_TH + HYST never wraps.
    localparam logic [DIST_W:0]   SET_TH    = (DIST_W+1)'(OBST_TH);
    localparam logic [DIST_W:0]   CLR_TH    = (DIST_W+1)'(OBST_TH + HYST);

    localparam logic [4:0] DIR_FWD   = 5'b00001;
    localparam logic [4:0] DIR_BACK  = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_RIGHT = 5'b01000;
    localparam logic [4:0] DIR_STOP  = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_BACK,
        S_TURN_L,
        S_TURN_R,
        S_FAULT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                blocked;
    logic                blocked_next;
    logic [DIST_W-1:0]   left_q;
    logic [DIST_W-1:0]   right_q;
    logic [TMR_W-1:0]    timer;
    logic [CLR_W-1:0]    clr_cnt;
    logic [3:0]          retry_cnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [PWM_W-1:0]    pwm_cnt_next;
    logic [PWM_W-1:0]    duty_active;
    logic [PWM_W-1:0]    duty_next;
    logic [PWM_W-1:0]    duty_target;
    logic [4:0]          dir_next;
    logic                fault_next;
    logic                pwm_next;
    logic [DIST_W:0]     front_ext;

`ifdef MOTOR_SOFTSTART_EN
    function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                     input logic [PWM_W-1:0] tgt);
        if (cur < tgt)
            return cur + PWM_W'(1);
        else if (cur > tgt)
            return cur - PWM_W'(1);
        else
            return cur;
    endfunction
`endif

    // Range sampling: hysteretic front flag, side samples kept for the turn choice
    always_comb begin
        front_ext    = {1'b0, distance_front};
        blocked_next = blocked;
        if (front_ext <= SET_TH)
            blocked_next = 1'b1;
        else if (front_ext >= CLR_TH)
            blocked_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (dist_valid) begin
            left_q  <= distance_left;
            right_q <= distance_right;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_next = S_FWD;
                S_FWD:    if (blocked) state_next = (retry_cnt < MAX_R) ? S_BACK : S_FAULT;
                S_BACK:   if (timer == '0) state_next = (left_q > right_q) ? S_TURN_L : S_TURN_R;
                S_TURN_L: if (timer == '0) state_next = S_FWD;
                S_TURN_R: if (timer == '0) state_next = S_FWD;
                S_FAULT:  state_next = S_FAULT;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs, decoded from the next state so the registered outputs track it
    always_comb begin
        dir_next    = DIR_STOP;
        duty_target = '0;
        fault_next  = 1'b0;
        case (state_next)
            S_FWD: begin
                dir_next    = DIR_FWD;
                duty_target = speed;
            end
            S_BACK: begin
                dir_next    = DIR_BACK;
                duty_target = TURN_DUTY;
            end
            S_TURN_L: begin
                dir_next    = DIR_LEFT;
                duty_target = TURN_DUTY;
            end
            S_TURN_R: begin
                dir_next    = DIR_RIGHT;
                duty_target = TURN_DUTY;
            end
            S_FAULT:  fault_next = 1'b1;
            default:  ;
        endcase
    end

    // PWM: duty only moves when the counter wraps, except the forced stop
    always_comb begin
        pwm_cnt_next = pwm_cnt + PWM_W'(1);
        duty_next    = duty_active;
        if (state_next == S_IDLE || state_next == S_FAULT) begin
            duty_next = '0;
        end else if (pwm_cnt_next == '0) begin
`ifdef MOTOR_SOFTSTART_EN
            duty_next = step_toward(duty_active, duty_target);
`else
            duty_next = duty_target;
`endif
        end
        pwm_next = (pwm_cnt_next < duty_next);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            blocked     <= 1'b0;
            timer       <= '0;
            clr_cnt     <= '0;
            retry_cnt   <= '0;
            pwm_cnt     <= '0;
            duty_active <= '0;
            direction   <= DIR_STOP;
            pwm_signal  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            direction   <= dir_next;
            fault       <= fault_next;
            pwm_cnt     <= pwm_cnt_next;
            duty_active <= duty_next;
            pwm_signal  <= pwm_next;

            if (dist_valid)
                blocked <= blocked_next;

            // One timer serves every manoeuvre: loaded on entry, counts down to 0.
            if (!enable) begin
                timer <= '0;
            end else if (state_next != state) begin
                case (state_next)
                    S_BACK:             timer <= BACK_LOAD;
                    S_TURN_L, S_TURN_R: timer <= TURN_LOAD;
                    default:            timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - TMR_W'(1);
            end

            // Blocked wins over a clear-counter completion in the same cycle.
            if (!enable) begin
                clr_cnt   <= '0;
                retry_cnt <= '0;
            end else if (state == S_FWD) begin
                if (blocked) begin
                    clr_cnt <= '0;
                    if (retry_cnt < MAX_R)
                        retry_cnt <= retry_cnt + 4'd1;
                end else if (clr_cnt == CLR_LAST) begin
                    clr_cnt   <= '0;
                    retry_cnt <= '0;
                end else begin
                    clr_cnt <= clr_cnt + CLR_W'(1);
                end
            end else begin
                clr_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/nav_motor_controller.md
# nav_motor_controller

Parametrised obstacle-avoidance motor controller for the RC platform, replacing the single-sensor, fixed-timer front-stop controller. It takes front, left and right range samples, applies threshold-with-hysteresis obstacle detection, and runs a forward / back-up / turn-toward-open-side sequence with programmable durations. A retry limit latches a fault when the car is boxed in. It drives the one-hot direction bus and a glitch-free PWM speed output.

## Interface
- DIST_W, 16: width of each distance input (sensor units, cm).
- OBST_TH, 13: front obstacle asserted when distance_front <= OBST_TH.
- HYST, 4: front obstacle cleared when distance_front >= OBST_TH + HYST.
- BACKUP_CYCLES, 6250000: BACKWARD duration in clk cycles, >= 1.
- TURN_CYCLES, 16777215: LEFT/RIGHT duration in clk cycles, >= 1.
- FWD_CLEAR_CYCLES, 12500000: consecutive FORWARD cycles that clear the retry count, >= 1.
- MAX_RETRY, 3: back-up/turn attempts allowed before FAULT, 1..15.
- PWM_W, 8: PWM counter and duty width.
- TURN_DUTY, 8'd160: duty used in BACKWARD, LEFT and RIGHT.
- clk, input, 1: system clock, 125 MHz.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: run request. Low forces STOP and clears any fault.
- dist_valid, input, 1: one-cycle strobe. All three distances are valid this cycle.
- distance_front / distance_left / distance_right, input, DIST_W each: range samples.
- speed, input, PWM_W: FORWARD duty.
- direction, output, 5: one-hot code.
  - FORWARD = 00001, BACKWARD = 00010, LEFT = 00100, RIGHT = 01000, STOP = 10000.
- pwm_signal, output, 1: motor enable PWM.
- fault, output, 1: boxed-in fault latched.

## Operation
- Range sampling: on dist_valid, the three distances are registered.
  - Front flag `blocked` is set if front <= OBST_TH, cleared if front >= OBST_TH + HYST, and otherwise held.
  - Compare in DIST_W+1 bits so OBST_TH + HYST cannot overflow.
- FSM states: IDLE, FWD, BACK, TURN_L, TURN_R, FAULT.
- IDLE (direction STOP): moves to FWD when enable = 1.
- FWD:
  - If blocked and retry_cnt < MAX_RETRY: go to BACK and increment retry_cnt.
  - If blocked and retry_cnt == MAX_RETRY: go to FAULT.
  - A clear-counter counts consecutive FWD cycles. At FWD_CLEAR_CYCLES, retry_cnt is set to 0.
- BACK: lasts exactly BACKUP_CYCLES cycles. On exit, the side is chosen from the registered samples:
  - left > right goes to TURN_L; otherwise (including a tie) to TURN_R.
- TURN_L / TURN_R: last exactly TURN_CYCLES cycles, then return to FWD. If still blocked, FWD re-enters BACK on the next cycle.
- FAULT: direction STOP, fault = 1, pwm low. Leaves only on reset, or enable = 0, which goes to IDLE and clears fault and retry_cnt.
- enable = 0 in any state: IDLE on the next edge. The timer, clear-counter and retry_cnt are cleared; `blocked` is kept.
- A single down-counter timer is loaded on entry to BACK/TURN_x. dist_valid arriving during BACK or TURN_x only updates `blocked`; it does not shorten the manoeuvre.
- PWM:
  - Free-running PWM_W-bit counter.
  - pwm_signal = (cnt < duty_active).
  - Target duty: speed in FWD, TURN_DUTY in BACK/TURN_x, 0 in IDLE/FAULT.
  - duty_active is loaded from the target only when cnt wraps to 0, so no partial-period glitches occur.
  - duty = 2^PWM_W − 1 gives high for all but one count; duty = 0 gives constant low.
  - Exception: entering IDLE or FAULT forces duty_active = 0 immediately.

## Timing
- Reset values:
  - direction = 10000, pwm_signal = 0, fault = 0.
  - State IDLE, retry_cnt = 0, blocked = 0, PWM counter = 0, duty_active = 0.
- Outputs are registered.
- Latency, dist_valid to direction change: `blocked` updates at edge +1, state/direction at edge +2.
- enable rise (from IDLE) to direction FORWARD: 1 cycle. enable fall to STOP: 1 cycle.
- BACKWARD asserted for exactly BACKUP_CYCLES cycles; LEFT/RIGHT for exactly TURN_CYCLES cycles.
- Simultaneous events:
  - Reset dominates everything.
  - enable = 0 dominates timer expiry and blocked.
  - In FWD, blocked dominates a clear-counter completion in the same cycle: retry_cnt increments and is not cleared.
- Reset mid-manoeuvre: returns to IDLE in the same edge with all counters zeroed.

## Configuration
- MOTOR_SOFTSTART_EN defined: at each PWM wrap, duty_active steps by 1 toward the target (up or down) instead of jumping. The forced 0 on IDLE/FAULT still applies.
- Not defined: duty_active takes the target directly at the next wrap.

## Test plan
- Bench parameters: BACKUP_CYCLES = 4, TURN_CYCLES = 6, FWD_CLEAR_CYCLES = 20, MAX_RETRY = 2, PWM_W = 4, TURN_DUTY = 8.
- Reset, then enable = 1 → STOP after reset, FORWARD 1 cycle after enable, fault = 0.
- dist_valid with front = 13, left = 40, right = 20 → BACKWARD 2 edges later for exactly 4 cycles, then LEFT for exactly 6 cycles, then FORWARD.
- Hysteresis: front sequence 13 → 15 → 17 → 12, each sample followed by ≥12 idle cycles.
  - blocked stays 1 on 15, clears on 17, sets again on 12.
  - Tie left = right = 30 → RIGHT.
- Boxed in: front held at 5 → BACK/TURN twice, then FAULT (direction 10000, fault = 1, pwm low).
  - enable 0 → 1 → fault clears, FORWARD.
- PWM with speed = 4 in FWD → high 4 of 16 counts.
  - Change speed to 12 mid-period → new duty only from the next wrap.
  - With MOTOR_SOFTSTART_EN: 4 → 5 → … → 12 over 8 periods.
- Reset asserted mid-BACKWARD → direction 10000 and pwm_signal 0 on the next edge. Re-enable → fresh FORWARD with retry_cnt = 0.
